// File: rtl/apb_param_mem_slave_if.sv
// APB slave-side bus bundle: request fields from the bridge, completion response back.
// Latency: none (wires only). Backpressure: m_ready stretches the access phase.
// Response fields are valid only while m_ready is high.
interface apb_param_mem_slave_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              m_error;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  m_rdata, m_ready, m_error
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output m_rdata, m_ready, m_error
    );
endinterface

// File: rtl/apb_param_mem_slave.sv
// APB slave over a DEPTH x DATA_W register file with byte strobes and error reporting.
// Latency: m_ready rises WAIT_STATES+1 cycles after the SETUP-state cycle.
// Backpressure: m_ready is held low for WAIT_STATES access cycles.
module apb_param_mem_slave #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    apb_param_mem_slave_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_strb;
    logic [DATA_W-1:0] rd_reg;
    logic              err_seen;
    logic [DATA_W-1:0] mem [DEPTH];

    logic in_range;
    logic mismatch;
    logic done;
    logic xfer_err;

    assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);
    assign mismatch = (bus.PADDR != lat_addr) || (bus.PWRITE != lat_write);
    assign done     = (state == ACCESS) && (cnt == 4'd0);
    // err_seen covers a request change in an earlier wait cycle that was since restored
    assign xfer_err = !in_range || err_seen || mismatch;

    assign bus.m_ready = done;
    assign bus.m_error = done && xfer_err;
    assign bus.m_rdata = (done && !lat_write && !xfer_err) ? rd_reg : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            rd_reg    <= '0;
            err_seen  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.PSELx && !bus.PENABLE) begin
                        state     <= SETUP;
                        lat_addr  <= bus.PADDR;
                        lat_write <= bus.PWRITE;
                        lat_wdata <= bus.PWDATA;
                        lat_strb  <= bus.PSTRB;
                        cnt       <= 4'(WAIT_STATES);
                    end
                end
                SETUP: begin
                    if (bus.PSELx && bus.PENABLE) begin
                        state    <= ACCESS;
                        rd_reg   <= in_range ? mem[lat_addr] : '0;
                        err_seen <= 1'b0;
                    end else if (!bus.PSELx) begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        if (!bus.PSELx || !bus.PENABLE) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                            if (mismatch) begin
                                err_seen <= 1'b1;
                            end
                        end
                    end else begin
                        if (lat_write && !xfer_err) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (lat_strb[b]) begin
                                    mem[lat_addr][8*b +: 8] <= lat_wdata[8*b +: 8];
                                end
                            end
                        end
                        // A new setup phase in the completion cycle chains the next transfer
                        if (bus.PSELx && !bus.PENABLE) begin
                            state     <= SETUP;
                            lat_addr  <= bus.PADDR;
                            lat_write <= bus.PWRITE;
                            lat_wdata <= bus.PWDATA;
                            lat_strb  <= bus.PSTRB;
                            cnt       <= 4'(WAIT_STATES);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_param_mem_slave.sv
// Randomized and directed APB transfers checked against a word-array model of the register file.
module tb_apb_param_mem_slave;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int WS     = 3;
    localparam int STRB_W = DATA_W / 8;

    localparam int M_NORM   = 0;
    localparam int M_GLITCH = 1;
    localparam int M_ABORT  = 2;
    localparam int M_RESET  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_param_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    apb_param_mem_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .PCLK(clk),
        .PRESETn(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic xfer(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input logic [STRB_W-1:0] strb, input int mode, output logic [DATA_W-1:0] rd);
        bit exp_err;
        logic [DATA_W-1:0] exp_rd;
        logic [DATA_W-1:0] mask;
        bit got_rdy;
        int k;
        exp_err = (int'(addr) >= DEPTH) || (mode == M_GLITCH);
        exp_rd  = '0;
        if (!wr && !exp_err) exp_rd = ref_mem[addr];
        rd = '0;
        got_rdy = 0;

        @(posedge clk); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wd; bus.PSTRB = strb;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;

        for (k = 0; k <= WS + 4; k++) begin
            @(negedge clk);
            if (bus.m_ready) begin
                got_rdy = 1;
                break;
            end
            if (mode == M_GLITCH && k == 1) bus.PADDR = addr ^ 4'h1;
            if (mode == M_GLITCH && k == 2) bus.PADDR = addr;
            if (mode == M_ABORT && k == 2) bus_idle();
            if (mode == M_RESET && k == 2) break;
        end

        if (mode == M_RESET) begin
            rst_n = 1'b0;
            #1;
            check_val("rst_mid_ready", DATA_W'(bus.m_ready), '0);
            check_val("rst_mid_error", DATA_W'(bus.m_error), '0);
            check_val("rst_mid_rdata", bus.m_rdata, '0);
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            @(posedge clk); #1;
            bus_idle();
            rst_n = 1'b1;
        end else if (mode == M_ABORT) begin
            check_val("abort_no_ready", DATA_W'(got_rdy), '0);
            bus_idle();
        end else begin
            check_val("ready_seen", DATA_W'(got_rdy), 1);
            if (got_rdy) begin
                check_val("latency", DATA_W'(k), DATA_W'(WS + 1));
                check_val("error", DATA_W'(bus.m_error), DATA_W'(exp_err));
                check_val("rdata", bus.m_rdata, exp_rd);
                rd = bus.m_rdata;
                if (wr && !exp_err) begin
                    mask = '0;
                    for (int b = 0; b < STRB_W; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
                    ref_mem[addr] = (ref_mem[addr] & ~mask) | (wd & mask);
                end
            end
            @(posedge clk); #1;
            bus_idle();
            @(negedge clk);
            check_val("single_pulse", DATA_W'(bus.m_ready), '0);
        end
    endtask

    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] rnd_dat;
    logic [STRB_W-1:0] rnd_strb;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus_idle();
        bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
        #1;
        check_val("reset_ready", DATA_W'(bus.m_ready), '0);
        check_val("reset_error", DATA_W'(bus.m_error), '0);
        check_val("reset_rdata", bus.m_rdata, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(0, 4'd0, '0, '0, M_NORM, rd);
        check_val("reset_mem0", rd, '0);

        // full-strobe write then read back
        xfer(1, 4'd3, 128'h0123456789ABCDEF0123456789ABCDEF, '1, M_NORM, rd);
        xfer(0, 4'd3, '0, '0, M_NORM, rd);
        check_val("t1_rdata", rd, 128'h0123456789ABCDEF0123456789ABCDEF);

        // partial strobes keep the unselected bytes
        xfer(1, 4'd3, '1, '1, M_NORM, rd);
        xfer(1, 4'd3, '0, 16'h00FF, M_NORM, rd);
        xfer(0, 4'd3, '0, '0, M_NORM, rd);
        check_val("t3_rdata", rd, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // out-of-range write and read
        xfer(1, 4'd14, {16{8'hAA}}, '1, M_NORM, rd);
        xfer(0, 4'd14, '0, '0, M_NORM, rd);
        check_val("oor_rdata", rd, '0);
        for (int a = 0; a < DEPTH; a++) xfer(0, ADDR_W'(a), '0, '0, M_NORM, rd);

        // request change in a wait cycle must error and suppress the write
        xfer(1, 4'd5, {16{8'h5A}}, '1, M_GLITCH, rd);
        xfer(0, 4'd5, '0, '0, M_NORM, rd);

        // abort before completion: no response, no write
        xfer(1, 4'd6, {16{8'hC3}}, '1, M_ABORT, rd);
        repeat (2) @(posedge clk);
        xfer(0, 4'd6, '0, '0, M_NORM, rd);

        // PENABLE while idle is ignored
        @(posedge clk); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = 4'd1; bus.PWRITE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("idle_penable", DATA_W'(bus.m_ready), '0);
        end
        @(posedge clk); #1;
        bus_idle();

        // reset mid-access drops the write and clears memory
        xfer(1, 4'd2, {16{8'h77}}, '1, M_NORM, rd);
        xfer(1, 4'd7, {16{8'h99}}, '1, M_RESET, rd);
        xfer(0, 4'd7, '0, '0, M_NORM, rd);
        check_val("rst_word7", rd, '0);
        xfer(0, 4'd2, '0, '0, M_NORM, rd);
        check_val("rst_word2", rd, '0);

        for (int n = 0; n < 60; n++) begin
            rnd_dat  = {$urandom, $urandom, $urandom, $urandom};
            rnd_strb = 16'($urandom);
            if (n % 7 == 0) rnd_strb = '1;
            if (n % 11 == 0) rnd_strb = '0;
            xfer(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), rnd_dat, rnd_strb, M_NORM, rd);
        end
        for (int a = 0; a < DEPTH; a++) xfer(0, ADDR_W'(a), '0, '0, M_NORM, rd);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
